// File: rtl/alu_operand_stage_pkg.sv
// Shared core constants for the ALU operand stage: operand-select encodings,
// the default datapath width and the constant used for the link-address operand.
package alu_operand_stage_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int CONST_FOUR   = 4;

    localparam logic [1:0] SRC1_RS1       = 2'd0;
    localparam logic [1:0] SRC1_PC        = 2'd1;
    localparam logic [1:0] SRC1_ZERO      = 2'd2;
    localparam logic [1:0] SRC1_ZERO_ALT  = 2'd3;

    localparam logic [1:0] SRC2_RS2       = 2'd0;
    localparam logic [1:0] SRC2_IMM       = 2'd1;
    localparam logic [1:0] SRC2_FOUR      = 2'd2;
    localparam logic [1:0] SRC2_ZERO      = 2'd3;

endpackage

// File: rtl/alu_operand_stage_fwd_resolve.sv
// Combinational bypass for one source register: picks the youngest matching
// forwarding source, never bypassing x0.
module fwd_resolve #(
    parameter int XLEN = 32,
    parameter int NFWD = 2
) (
    input  logic [4:0]           addr,
    input  logic [XLEN-1:0]      reg_data,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD*5-1:0]    fwd_rd,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    output logic [XLEN-1:0]      data,
    output logic                 hit
);

    // Walk from oldest to youngest so the lowest index wins.
    always_comb begin
        data = reg_data;
        hit  = 1'b0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_rd[i*5 +: 5] == addr) && (addr != 5'd0)) begin
                data = fwd_data[i*XLEN +: XLEN];
                hit  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand stage: resolves forwarding, selects operands and registers them
// behind a valid/ready skid-free pipeline register with a forwarding-hit counter.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NFWD = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           rs1_addr,
    input  logic [4:0]           rs2_addr,
    input  logic [XLEN-1:0]      rs1_data,
    input  logic [XLEN-1:0]      rs2_data,
    input  logic [XLEN-1:0]      imm_ext,
    input  logic [XLEN-1:0]      pc,
    input  logic [1:0]           alu_src1,
    input  logic [1:0]           alu_src2,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD*5-1:0]    fwd_rd,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      op_a,
    output logic [XLEN-1:0]      op_b,
    output logic [XLEN-1:0]      store_data,
    output logic [15:0]          fwd_hits
);

    logic [XLEN-1:0] rs1_res;
    logic [XLEN-1:0] rs2_res;
    logic            rs1_hit;
    logic            rs2_hit;
    logic [XLEN-1:0] op_a_nxt;
    logic [XLEN-1:0] op_b_nxt;
    logic            accept;
    logic [1:0]      hit_inc;
    logic [16:0]     hits_sum;

    fwd_resolve #(.XLEN(XLEN), .NFWD(NFWD)) u_rs1 (
        .addr      (rs1_addr),
        .reg_data  (rs1_data),
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data),
        .data      (rs1_res),
        .hit       (rs1_hit)
    );

    fwd_resolve #(.XLEN(XLEN), .NFWD(NFWD)) u_rs2 (
        .addr      (rs2_addr),
        .reg_data  (rs2_data),
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data),
        .data      (rs2_res),
        .hit       (rs2_hit)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        case (alu_src1)
            SRC1_RS1: op_a_nxt = rs1_res;
            SRC1_PC:  op_a_nxt = pc;
            default:  op_a_nxt = '0;
        endcase
        case (alu_src2)
            SRC2_RS2:  op_b_nxt = rs2_res;
            SRC2_IMM:  op_b_nxt = imm_ext;
            SRC2_FOUR: op_b_nxt = XLEN'(CONST_FOUR);
            default:   op_b_nxt = '0;
        endcase
    end

    // store_data always carries resolved rs2, so an rs2 hit is always consumed.
    assign hit_inc  = {1'b0, (alu_src1 == SRC1_RS1) && rs1_hit} + {1'b0, rs2_hit};
    assign hits_sum = {1'b0, fwd_hits} + {15'd0, hit_inc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            store_data <= '0;
            fwd_hits   <= '0;
        end else begin
            if (accept) begin
                op_a       <= op_a_nxt;
                op_b       <= op_b_nxt;
                store_data <= rs2_res;
            end
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                fwd_hits  <= hits_sum[16] ? 16'hFFFF : hits_sum[15:0];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: operand select, forwarding priority,
// x0 guard, backpressure, flush, reset and counter saturation.
module tb_alu_operand_stage;

    localparam int XLEN = 32;
    localparam int NFWD = 2;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [4:0]           rs1_addr;
    logic [4:0]           rs2_addr;
    logic [XLEN-1:0]      rs1_data;
    logic [XLEN-1:0]      rs2_data;
    logic [XLEN-1:0]      imm_ext;
    logic [XLEN-1:0]      pc;
    logic [1:0]           alu_src1;
    logic [1:0]           alu_src2;
    logic [NFWD-1:0]      fwd_valid;
    logic [NFWD*5-1:0]    fwd_rd;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      op_a;
    logic [XLEN-1:0]      op_b;
    logic [XLEN-1:0]      store_data;
    logic [15:0]          fwd_hits;

    int checks = 0;
    int errors = 0;

    alu_operand_stage #(.XLEN(XLEN), .NFWD(NFWD)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .imm_ext    (imm_ext),
        .pc         (pc),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .store_data (store_data),
        .fwd_hits   (fwd_hits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; rs1_addr = '0; rs2_addr = '0;
        rs1_data = '0; rs2_data = '0; imm_ext = '0; pc = '0;
        alu_src1 = 2'd0; alu_src2 = 2'd0; fwd_valid = '0; fwd_rd = '0;
        fwd_data = '0; flush = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_op_a", op_a, 32'd0);
        chk("rst_fwd_hits", 32'(fwd_hits), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // operand select without forwarding
        rs2_data = 32'd2; imm_ext = 32'd4; alu_src2 = 2'd0; in_valid = 1'b1;
        step();
        chk("sel_rs2_op_b", op_b, 32'd2);
        chk("sel_rs2_valid", 32'(out_valid), 32'd1);
        alu_src2 = 2'd1;
        step();
        chk("sel_imm_op_b", op_b, 32'd4);
        chk("sel_no_hits", 32'(fwd_hits), 32'd0);

        // forwarding priority: youngest source wins
        rs1_addr = 5'd5; rs1_data = 32'h77; alu_src1 = 2'd0;
        fwd_valid = 2'b11; fwd_rd = {5'd5, 5'd5}; fwd_data = {32'h22, 32'h11};
        step();
        chk("prio_op_a", op_a, 32'h11);
        chk("prio_hits", 32'(fwd_hits), 32'd1);
        fwd_valid = 2'b10;
        step();
        chk("prio_fwd1_op_a", op_a, 32'h22);
        chk("prio_fwd1_hits", 32'(fwd_hits), 32'd2);
        fwd_valid = 2'b00;
        step();
        chk("nofwd_op_a", op_a, 32'h77);
        chk("nofwd_hits", 32'(fwd_hits), 32'd2);

        // x0 is never forwarded
        rs1_addr = 5'd0; rs1_data = '0; rs2_addr = 5'd0; rs2_data = '0; alu_src2 = 2'd0;
        fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd0}; fwd_data = {32'h0, 32'hFF};
        step();
        chk("x0_op_b", op_b, 32'd0);
        chk("x0_store", store_data, 32'd0);
        chk("x0_hits", 32'(fwd_hits), 32'd2);

        // store_data forwards even when op_b takes the immediate
        rs2_addr = 5'd3; rs2_data = 32'h99; alu_src1 = 2'd2; alu_src2 = 2'd1;
        fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd3}; fwd_data = {32'h0, 32'h33};
        step();
        chk("st_op_a_zero", op_a, 32'd0);
        chk("st_op_b_imm", op_b, 32'd4);
        chk("st_store_fwd", store_data, 32'h33);
        chk("st_hits", 32'(fwd_hits), 32'd3);

        // rs1 hit not counted when op_a is not rs1; constant selects
        rs2_addr = 5'd0; rs1_addr = 5'd5; alu_src1 = 2'd3; alu_src2 = 2'd2;
        fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd5}; fwd_data = {32'h0, 32'h55};
        step();
        chk("c4_op_a", op_a, 32'd0);
        chk("c4_op_b", op_b, 32'd4);
        chk("c4_hits", 32'(fwd_hits), 32'd3);
        alu_src2 = 2'd3; fwd_valid = 2'b00;
        step();
        chk("zero_op_b", op_b, 32'd0);

        // backpressure
        rs1_addr = 5'd0; alu_src1 = 2'd1; alu_src2 = 2'd1; pc = 32'h100;
        step();
        chk("bp_accept_op_a", op_a, 32'h100);
        out_ready = 1'b0; pc = 32'h200;
        #1;
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_hold_op_a", op_a, 32'h100);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("b2b_op_a", op_a, 32'h200);
        chk("b2b_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        step();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // flush overrides an accept and does not count hits
        in_valid = 1'b1; alu_src1 = 2'd0; rs1_addr = 5'd7;
        fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd7}; fwd_data = {32'h0, 32'h70};
        flush = 1'b1;
        step();
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_hits", 32'(fwd_hits), 32'd3);
        flush = 1'b0; fwd_valid = 2'b00; rs1_addr = 5'd0;

        // reset mid-stall
        alu_src1 = 2'd1; pc = 32'h300; out_ready = 1'b0;
        step();
        step();
        chk("stall_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid_valid", 32'(out_valid), 32'd0);
        chk("rstmid_op_a", op_a, 32'd0);
        chk("rstmid_store", store_data, 32'd0);
        chk("rstmid_hits", 32'(fwd_hits), 32'd0);
        chk("rstmid_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("rst_no_accept", 32'(out_valid), 32'd0);
        rst = 1'b0;
        step();
        chk("resume_valid", 32'(out_valid), 32'd1);
        chk("resume_op_a", op_a, 32'h300);

        // saturation with double-hit accepts
        out_ready = 1'b1; alu_src1 = 2'd0; alu_src2 = 2'd0;
        rs1_addr = 5'd5; rs2_addr = 5'd6;
        fwd_valid = 2'b11; fwd_rd = {5'd6, 5'd5}; fwd_data = {32'h66, 32'h55};
        step();
        chk("dbl_hits", 32'(fwd_hits), 32'd2);
        chk("dbl_op_a", op_a, 32'h55);
        chk("dbl_op_b", op_b, 32'h66);
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_hits", 32'(fwd_hits), 32'hFFFF);
        step();
        chk("sat_hold", 32'(fwd_hits), 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
